// File: rtl/hpdmc_ddr_wrseq_if.sv
// Write-sequencer bus: burst request handshake, burst payload and the
// per-clock DQ/DM/DQS drive signals going to the output DDR registers.
interface hpdmc_ddr_wrseq_if #(
  parameter int DQ_W  = 16,
  parameter int BURST = 4
);
  localparam int DM_W = DQ_W / 8;

  logic                    start;
  logic                    ready;
  logic [BURST*DQ_W-1:0]   din;
  logic [BURST*DM_W-1:0]   dmin;
  logic [DQ_W-1:0]         dq_r;
  logic [DQ_W-1:0]         dq_f;
  logic [DM_W-1:0]         dm_r;
  logic [DM_W-1:0]         dm_f;
  logic                    dq_oe;
  logic                    dqs_oe;
  logic                    dqs_en;
  logic                    busy;
  logic                    done;

  // Requester side: command FSM / datapath consumer
  modport master (
    output start, din, dmin,
    input  ready, dq_r, dq_f, dm_r, dm_f, dq_oe, dqs_oe, dqs_en, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, din, dmin,
    output ready, dq_r, dq_f, dm_r, dm_f, dq_oe, dqs_oe, dqs_en, busy, done
  );
endinterface

// File: rtl/hpdmc_ddr_wrseq.sv
// DDR16 write-data sequencer. Latches one write burst on accept, waits the
// write latency, then presents rising/falling-edge DQ/DM halves per clock with
// DQS preamble, toggle window and postamble enables. All drive outputs are
// registered; ready is decoded combinationally from the current state.
module hpdmc_ddr_wrseq #(
  parameter int DQ_W  = 16,
  parameter int BURST = 4,
  parameter int WL    = 1
) (
  input  logic                 c,
  input  logic                 clr,
  hpdmc_ddr_wrseq_if.slave     bus
);

  localparam int DM_W  = DQ_W / 8;
  localparam int HALF  = BURST / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BEAT_ONE  = CNT_W'(1);
  // WAIT holds for WL-1 clocks; the counter is loaded with the remaining count.
  localparam logic [1:0]       WAIT_INIT = (WL > 1) ? 2'(WL - 2) : 2'd0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;

  logic [2:0]            state_q,  state_d;
  logic [CNT_W-1:0]      beat_q,   beat_d;
  logic [1:0]            wait_q,   wait_d;
  logic [BURST*DQ_W-1:0] din_q,    din_d;
  logic [BURST*DM_W-1:0] dmin_q,   dmin_d;
  logic [DQ_W-1:0]       dq_r_q,   dq_r_d;
  logic [DQ_W-1:0]       dq_f_q,   dq_f_d;
  logic [DM_W-1:0]       dm_r_q,   dm_r_d;
  logic [DM_W-1:0]       dm_f_q,   dm_f_d;
  logic                  dq_oe_q,  dq_oe_d;
  logic                  dqs_oe_q, dqs_oe_d;
  logic                  dqs_en_q, dqs_en_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;

  logic                  ready_s;
  logic                  accept_s;

  // A new burst may only be taken while idle or in the postamble clock
  always_comb begin
    ready_s  = (state_q == S_IDLE) || (state_q == S_POST);
    accept_s = bus.start && ready_s;
  end

  // Sequencer next state, beat/wait counters and burst holding registers
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    din_d   = din_q;
    dmin_d  = dmin_q;
    case (state_q)
      S_IDLE, S_POST: begin
        if (accept_s) begin
          din_d  = bus.din;
          dmin_d = bus.dmin;
          if (WL == 1) begin
            state_d = S_PRE;
            wait_d  = 2'd0;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = S_PRE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_PRE: begin
        state_d = S_DATA;
        beat_d  = {CNT_W{1'b0}};
      end
      S_DATA: begin
        // Counter parks on the last pair; it never wraps inside a burst
        if (beat_q == BEAT_LAST) begin
          state_d = S_POST;
        end else begin
          beat_d = beat_q + BEAT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming clock, decoded from the next state
  always_comb begin
    dq_r_d   = {DQ_W{1'b0}};
    dq_f_d   = {DQ_W{1'b0}};
    dm_r_d   = {DM_W{1'b0}};
    dm_f_d   = {DM_W{1'b0}};
    dq_oe_d  = 1'b0;
    dqs_oe_d = 1'b0;
    dqs_en_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_IDLE: begin
        dqs_oe_d = 1'b0;
      end
      S_WAIT: begin
        // Keep DQS driven through a latency gap between chained bursts
        dqs_oe_d = dqs_oe_q;
      end
      S_PRE: begin
        dqs_oe_d = 1'b1;
      end
      S_DATA: begin
        dq_r_d   = din_q[(2 * int'(beat_d)) * DQ_W +: DQ_W];
        dq_f_d   = din_q[(2 * int'(beat_d) + 1) * DQ_W +: DQ_W];
        dm_r_d   = dmin_q[(2 * int'(beat_d)) * DM_W +: DM_W];
        dm_f_d   = dmin_q[(2 * int'(beat_d) + 1) * DM_W +: DM_W];
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        dqs_en_d = 1'b1;
      end
      S_POST: begin
        dqs_oe_d = 1'b1;
        done_d   = 1'b1;
      end
      default: begin
        dqs_oe_d = 1'b0;
      end
    endcase
  end

  // State, counters, holding registers and registered outputs
  always_ff @(posedge c or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      beat_q   <= {CNT_W{1'b0}};
      wait_q   <= 2'd0;
      din_q    <= {(BURST*DQ_W){1'b0}};
      dmin_q   <= {(BURST*DM_W){1'b0}};
      dq_r_q   <= {DQ_W{1'b0}};
      dq_f_q   <= {DQ_W{1'b0}};
      dm_r_q   <= {DM_W{1'b0}};
      dm_f_q   <= {DM_W{1'b0}};
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
      dqs_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      din_q    <= din_d;
      dmin_q   <= dmin_d;
      dq_r_q   <= dq_r_d;
      dq_f_q   <= dq_f_d;
      dm_r_q   <= dm_r_d;
      dm_f_q   <= dm_f_d;
      dq_oe_q  <= dq_oe_d;
      dqs_oe_q <= dqs_oe_d;
      dqs_en_q <= dqs_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready  = ready_s;
  assign bus.dq_r   = dq_r_q;
  assign bus.dq_f   = dq_f_q;
  assign bus.dm_r   = dm_r_q;
  assign bus.dm_f   = dm_f_q;
  assign bus.dq_oe  = dq_oe_q;
  assign bus.dqs_oe = dqs_oe_q;
  assign bus.dqs_en = dqs_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
